// File: rtl/acc_feeder_pkg.sv
// acc_feeder_pkg: shared state encoding and width helpers for the operand feeder.
package acc_feeder_pkg;

    typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

    function automatic int cnt_width(int hold, int gap);
        return $clog2(hold > gap ? hold : gap) + 1;
    endfunction

    function automatic int count_width(int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/acc_operand_fifo.sv
// acc_operand_fifo: synchronous operand FIFO with flush; pointers wrap modulo DEPTH.
module acc_operand_fifo
    import acc_feeder_pkg::*;
#(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          push,
    input  logic                          pop,
    input  logic                          flush,
    input  logic [W-1:0]                  din,
    output logic [W-1:0]                  dout,
    output logic                          full,
    output logic                          empty,
    output logic [count_width(DEPTH)-1:0] count
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CNW = count_width(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic          wr, rd;

    assign wr    = push && !full;
    assign rd    = pop && !empty;
    assign full  = count == CNW'(DEPTH);
    assign empty = count == '0;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk)
        if (wr) mem[wr_ptr] <= din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + AW'(1);
            if (rd) rd_ptr <= rd_ptr + AW'(1);
            count <= count + CNW'(wr) - CNW'(rd);
        end
    end

endmodule

// File: rtl/acc_mult_operand_feeder.sv
// acc_mult_operand_feeder: buffers operand pairs and sequences them into the accumulating
// multiplier with a fixed enable window and gap, capturing the sum at window end.
module acc_mult_operand_feeder
    import acc_feeder_pkg::*;
#(
    parameter int WIDTH1      = 8,
    parameter int WIDTH2      = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                               sys_clk,
    input  logic                               sys_rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH1-1:0]                  in_a,
    input  logic [WIDTH2-1:0]                  in_b,
    input  logic                               in_cin,
    input  logic                               flush,
    output logic                               en,
    output logic [WIDTH1-1:0]                  A,
    output logic [WIDTH2-1:0]                  B,
    output logic                               cin,
    input  logic [WIDTH1+WIDTH2-1:0]           sum_in,
    output logic                               res_valid,
    output logic [WIDTH1+WIDTH2-1:0]           res_data,
    output logic                               busy,
    output logic [count_width(FIFO_DEPTH)-1:0] fifo_count
);
    localparam int DW = WIDTH1 + WIDTH2 + 1;
    localparam int CW = cnt_width(HOLD_CYCLES, GAP_CYCLES);

    state_t        state;
    logic [CW-1:0] cnt;
    logic [DW-1:0] head;
    logic          full, empty, push, pop;

    assign in_ready = !full;
    assign push     = in_valid && !full && !flush;
    // A new pair is issued from IDLE or straight out of an expiring gap.
    assign pop      = !flush && !empty && (state == IDLE || (state == GAP && cnt == '0));
    assign busy     = state != IDLE;

    acc_operand_fifo #(
        .W     (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ({in_cin, in_a, in_b}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            en        <= 1'b0;
            A         <= '0;
            B         <= '0;
            cin       <= 1'b0;
            res_valid <= 1'b0;
            res_data  <= '0;
        end else if (flush) begin
            state     <= IDLE;
            cnt       <= '0;
            en        <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            res_valid <= 1'b0;
            if (pop) begin
                {cin, A, B} <= head;
                en          <= 1'b1;
                cnt         <= CW'(HOLD_CYCLES - 1);
                state       <= HOLD;
            end else begin
                case (state)
                    HOLD: begin
                        if (cnt != '0) begin
                            cnt <= cnt - CW'(1);
                        end else begin
                            en        <= 1'b0;
                            res_data  <= sum_in;
                            res_valid <= 1'b1;
                            cnt       <= CW'(GAP_CYCLES - 1);
                            state     <= GAP;
                        end
                    end
                    GAP: begin
                        if (cnt != '0) cnt <= cnt - CW'(1);
                        else state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_acc_mult_operand_feeder.sv
// tb_acc_mult_operand_feeder: vector table plus scoreboard checks of the operand feeder,
// with a behavioural multiplier stub producing sum_in = A*B + cin.
module tb_acc_mult_operand_feeder;
    localparam int W1 = 8, W2 = 8, DEPTH = 4, HOLD = 4, GAP = 1;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        c;
        logic [15:0] exp;
    } vec_t;

    logic        sys_clk, sys_rst_n, in_valid, in_ready, in_cin, flush;
    logic [7:0]  in_a, in_b, A, B;
    logic        en, cin, res_valid, busy;
    logic [15:0] sum_in, res_data;
    logic [2:0]  fifo_count;

    int   checks = 0, errors = 0, results = 0;
    int   hold_n = 0, en_cnt = 0, busy_cnt = 0;
    bit   have_cur = 0, saw_full = 0, en_q = 0;
    vec_t cur;
    vec_t exp_q[$];
    vec_t tbl[7];

    acc_mult_operand_feeder #(
        .WIDTH1      (W1),
        .WIDTH2      (W2),
        .FIFO_DEPTH  (DEPTH),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAP)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_cin     (in_cin),
        .flush      (flush),
        .en         (en),
        .A          (A),
        .B          (B),
        .cin        (cin),
        .sum_in     (sum_in),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    assign sum_in = {8'd0, A} * {8'd0, B} + {15'd0, cin};

    initial sys_clk = 0;
    always #5 sys_clk = ~sys_clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Scoreboard: pairs are matched to issue windows in order, results to their pair.
    always @(negedge sys_clk) begin
        if (sys_rst_n) begin
            chk("in_ready", in_ready, fifo_count != 3'd4);
            if (fifo_count == 3'd4 && !in_ready) saw_full = 1;
            if (en) en_cnt++;
            if (busy) busy_cnt++;
            if (en && !en_q) begin
                chk("issue_queued", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                end
                hold_n = 0;
            end
            if (en) begin
                hold_n++;
                chk("A", A, cur.a);
                chk("B", B, cur.b);
                chk("cin", cin, cur.c);
            end
            if (res_valid) begin
                chk("result_expected", have_cur, 1);
                chk("res_data", res_data, cur.exp);
                chk("hold_len", hold_n, HOLD);
                results++;
                have_cur = 0;
            end
        end
        en_q = en;
    end

    task automatic sync();
        @(posedge sys_clk);
        #1;
    endtask

    // Must be called between a rising edge and the following falling edge.
    task automatic send(input vec_t v);
        bit ok = 0;
        in_valid = 1;
        in_a = v.a;
        in_b = v.b;
        in_cin = v.c;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (in_ready) begin
                ok = 1;
                break;
            end
        end
        chk("send_ready", ok, 1);
        sync();
        if (ok) exp_q.push_back(v);
        in_valid = 0;
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge sys_clk);
            if (!busy && exp_q.size() == 0 && !have_cur) begin
                done = 1;
                break;
            end
        end
        chk("wait_idle", done, 1);
    endtask

    initial begin
        tbl[0] = '{8'd25,  8'd10,  1'b0, 16'd250};
        tbl[1] = '{8'd1,   8'd2,   1'b0, 16'd2};
        tbl[2] = '{8'd3,   8'd4,   1'b0, 16'd12};
        tbl[3] = '{8'd5,   8'd6,   1'b0, 16'd30};
        tbl[4] = '{8'd7,   8'd8,   1'b0, 16'd56};
        tbl[5] = '{8'd9,   8'd10,  1'b0, 16'd90};
        tbl[6] = '{8'hFD,  8'hFC,  1'b1, 16'd63757};
        sys_rst_n = 0;
        in_valid = 0;
        in_a = 0;
        in_b = 0;
        in_cin = 0;
        flush = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_outputs", {en, A, B, cin, res_valid, fifo_count}, 0);
        chk("rst_res_data", res_data, 0);
        sys_rst_n = 1;
        repeat (20) begin
            @(negedge sys_clk);
            chk("idle_outputs", {en, A, B, res_valid, fifo_count, busy}, 0);
        end
        // single pair: latency and single result
        sync();
        send(tbl[0]);
        @(negedge sys_clk);
        chk("lat_en_low", en, 0);
        chk("lat_count1", fifo_count, 1);
        @(negedge sys_clk);
        chk("lat_en_high", en, 1);
        chk("lat_busy", busy, 1);
        wait_idle();
        chk("single_busy_off", busy, 0);
        chk("single_results", results, 1);
        // back-to-back stream fills the FIFO
        sync();
        en_cnt = 0;
        busy_cnt = 0;
        saw_full = 0;
        for (int i = 1; i <= 5; i++) send(tbl[i]);
        wait_idle();
        chk("burst_full_seen", saw_full, 1);
        chk("burst_en_cycles", en_cnt, 5 * HOLD);
        chk("burst_busy_cycles", busy_cnt, 5 * (HOLD + GAP));
        chk("burst_results", results, 6);
        // negative bit patterns pass unchanged
        sync();
        send(tbl[6]);
        wait_idle();
        chk("neg_results", results, 7);
        // flush in 2nd hold cycle with two pairs queued
        sync();
        send(tbl[1]);
        send(tbl[2]);
        send(tbl[3]);
        chk("flush_pre_count", fifo_count, 2);
        chk("flush_pre_en", en, 1);
        flush = 1;
        in_valid = 1;
        in_a = tbl[4].a;
        in_b = tbl[4].b;
        in_cin = tbl[4].c;
        sync();
        flush = 0;
        in_valid = 0;
        exp_q.delete();
        have_cur = 0;
        @(negedge sys_clk);
        chk("flush_en", en, 0);
        chk("flush_count", fifo_count, 0);
        chk("flush_busy", busy, 0);
        repeat (10) begin
            @(negedge sys_clk);
            chk("flush_no_result", {res_valid, en}, 0);
        end
        chk("flush_res_keep", res_data, 16'd63757);
        sync();
        send(tbl[4]);
        wait_idle();
        chk("post_flush_results", results, 8);
        // asynchronous reset in the middle of a hold window
        sync();
        send(tbl[5]);
        send(tbl[1]);
        @(negedge sys_clk);
        chk("arst_pre_en", en, 1);
        #2;
        sys_rst_n = 0;
        #1;
        chk("arst_outputs", {en, A, B, cin, fifo_count, busy}, 0);
        exp_q.delete();
        have_cur = 0;
        @(posedge sys_clk);
        #3;
        sys_rst_n = 1;
        repeat (15) begin
            @(negedge sys_clk);
            chk("arst_no_stale", {en, fifo_count, busy}, 0);
        end
        chk("final_results", results, 8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
